setting_entry: RTL
==================

Name: setting_entry

Overview:
- Operator-input stage directly upstream of the bottling controller.
- Debounces the three front-panel buttons (Pulse, QD, CLR) and lets the operator edit a 3-digit BCD pills-per-bottle target and a 2-digit BCD bottle-count target.
- On confirmation, latches both targets as binary and emits a one-cycle start pulse that moves the controller out of SETTING.
- Drives the five right-hand display digits and their blink mask while in edit mode.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive stable samples (clk_1khz cycles, i.e. 20 ms) required before a button level is accepted.
- CNT_W, 5, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_1khz  input  1  sole clock, 1 kHz.
- rst_n  input  1  asynchronous active-low reset.
- btn_inc  input  1  raw Pulse button, active-high, asynchronous to clk.
- btn_next  input  1  raw QD button, active-high, asynchronous.
- btn_clr  input  1  raw CLR button, already inverted to active-high by the top level, asynchronous.
- target_pills  output  10  binary pills per bottle, 0..999.
- target_bottles  output  7  binary bottle count, 0..99.
- start_pulse  output  1  one-cycle strobe on accepted confirm.
- reject_pulse  output  1  one-cycle strobe when confirm is refused.
- locked  output  1  high while targets are committed.
- disp_digits  output  20  BCD digits {P2,P1,P0,B1,B0}, MSB nibble = pills hundreds.
- flicker_mask  output  5  blink enable per digit, same ordering as disp_digits (bit4 = P2).

Behaviour:
- Reset (async, rst_n low):
  - all BCD digits 0; state EDIT_P2
  - target_pills 0, target_bottles 0
  - start_pulse, reject_pulse, locked all 0
  - flicker_mask 5'b10000
  - debounce state cleared, accepted button levels 0
- Synchronisation and debounce:
  - Each button passes through a 2-flop synchroniser, then a counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples differ from it; any mismatch-free sample resets the counter.
  - A rising edge of the accepted level gives a one-cycle event.
  - Latency from a clean press to event: 2 + DEBOUNCE_CYCLES cycles.
- Event priority when events coincide in one cycle: clr > next > inc. Lower-priority events in that cycle are discarded.
- States: EDIT_P2, EDIT_P1, EDIT_P0, EDIT_B1, EDIT_B0, CONFIRM, LOCKED.
- inc event:
  - In an EDIT_x state, the selected digit increments 9 -> 0 with wrap; no carry into neighbouring digits.
  - Ignored in CONFIRM and LOCKED.
- next event:
  - Advances EDIT_P2 -> EDIT_P1 -> EDIT_P0 -> EDIT_B1 -> EDIT_B0 -> CONFIRM.
  - In CONFIRM:
    - If pills value != 0 and bottles value != 0: load target_pills = 100*P2 + 10*P1 + P0 and target_bottles = 10*B1 + B0, go to LOCKED, and assert start_pulse for exactly the next cycle.
    - Otherwise: go to EDIT_P2, assert reject_pulse for one cycle, keep digits.
  - Ignored in LOCKED.
- clr event:
  - In EDIT_x or CONFIRM: all digits set to 0, state EDIT_P2.
  - In LOCKED: state EDIT_P2, digits retained, targets retained, no pulse.
- Outputs per state:
  - locked = 1 only in LOCKED.
  - flicker_mask is one-hot on the selected digit in EDIT_x, 5'b11111 in CONFIRM, 5'b00000 in LOCKED.
- target_pills and target_bottles change only on accepted confirm and are stable otherwise, including while editing after an unlock.
- start_pulse and the new target values become visible on the same clock edge.
- Arithmetic: BCD-to-binary uses shift-add (x100 = x64 + x32 + x4, x10 = x8 + x2). Results fit in 10 and 7 bits without truncation.
- Reset asserted mid-press or mid-debounce: all state returns to reset values. A button still held at reset release produces an event after debounce completes.

Decomposition:
- Package setting_entry_pkg:
  - state enum: 3-bit encoding, EDIT_P2 = 0 through LOCKED = 6
  - DIGIT_P2..DIGIT_B0 index constants
  - default DEBOUNCE_CYCLES
- Sub-module btn_debounce (synchroniser + counter + rising-edge pulse), instantiated three times.
- BCD-to-binary conversion stays inline.

Test Plan:
- Reset, then press next x5 with no inc, then next again -> reject_pulse for 1 cycle, state EDIT_P2, targets stay 0, start_pulse never asserted.
- Set P2..B0 = 1,2,0,0,5 via inc presses, next x5, next -> start_pulse for 1 cycle, target_pills = 120, target_bottles = 5, locked = 1, flicker_mask = 00000.
- In EDIT_P0, press inc 10 times -> digit returns to its starting value, P1 unchanged.
- Bouncy press: btn_inc toggles every 3 cycles for 15 cycles, then holds high -> exactly one inc event, 22 cycles after the final stable edge.
- btn_clr and btn_next debounced on the same cycle in CONFIRM -> digits all 0, EDIT_P2, no start_pulse or reject_pulse.
- While LOCKED, press clr -> EDIT_P2 with digits and targets intact. Confirm again unchanged -> start_pulse, same targets. Assert rst_n low mid-debounce -> all outputs at reset values immediately.

Source files
------------

// File: rtl/setting_entry_pkg.sv
// Shared definitions for the setting_entry operator-input stage:
// FSM state encoding, display digit positions and button indices.
package setting_entry_pkg;

   // Edit-FSM states; the EDIT_x states are contiguous so "next" is +1.
   typedef logic [2:0] state_t;
   localparam state_t EDIT_P2 = 3'd0;
   localparam state_t EDIT_P1 = 3'd1;
   localparam state_t EDIT_P0 = 3'd2;
   localparam state_t EDIT_B1 = 3'd3;
   localparam state_t EDIT_B0 = 3'd4;
   localparam state_t CONFIRM = 3'd5;
   localparam state_t LOCKED  = 3'd6;

   // Digit positions in the packed display vector (index 4 = MSB nibble).
   localparam int NUM_DIGITS = 5;
   localparam int DIGIT_P2   = 4;
   localparam int DIGIT_P1   = 3;
   localparam int DIGIT_P0   = 2;
   localparam int DIGIT_B1   = 1;
   localparam int DIGIT_B0   = 0;

   // Button lanes feeding the debouncer array.
   localparam int NUM_BTNS = 3;
   localparam int BTN_INC  = 0;
   localparam int BTN_NEXT = 1;
   localparam int BTN_CLR  = 2;

   localparam int DEF_DEBOUNCE_CYCLES = 20;

endpackage

// File: rtl/setting_entry_btn_debounce.sv
// One front-panel button: 2-flop synchroniser, stability counter and
// rising-edge pulse on the accepted level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int CNT_W           = 5
) (
   input  logic clk_1khz,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_rise
);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             level;
   logic             level_q;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[0], btn_raw};
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync[1] != level) begin
         if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // Delayed level for edge detection.
   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) level_q <= 1'b0;
      else        level_q <= level;
   end

   assign btn_rise = level & ~level_q;

endmodule

// File: rtl/setting_entry.sv
// Operator setting entry: debounced buttons edit 3 BCD pill digits and
// 2 BCD bottle digits; a confirmed non-zero setting is latched as binary
// targets together with a one-cycle start strobe.
module setting_entry
   import setting_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 5
) (
   input  logic        clk_1khz,
   input  logic        rst_n,
   input  logic        btn_inc,
   input  logic        btn_next,
   input  logic        btn_clr,
   output logic [9:0]  target_pills,
   output logic [6:0]  target_bottles,
   output logic        start_pulse,
   output logic        reject_pulse,
   output logic        locked,
   output logic [19:0] disp_digits,
   output logic [4:0]  flicker_mask
);

   logic [NUM_BTNS-1:0]        btn_raw;
   logic [NUM_BTNS-1:0]        btn_rise;
   logic [NUM_DIGITS-1:0][3:0] digits;
   state_t                     state;
   logic                       ev_inc, ev_next, ev_clr;
   logic                       in_edit;
   logic [2:0]                 sel_idx;
   logic [9:0]                 pills_bin;
   logic [6:0]                 bottles_bin;
   logic                       setting_ok;

   assign btn_raw = {btn_clr, btn_next, btn_inc};

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk_1khz (clk_1khz),
         .rst_n    (rst_n),
         .btn_raw  (btn_raw[g]),
         .btn_rise (btn_rise[g])
      );
   end

   // Coincident events: clr wins over next, next wins over inc.
   assign ev_clr  = btn_rise[BTN_CLR];
   assign ev_next = btn_rise[BTN_NEXT] & ~ev_clr;
   assign ev_inc  = btn_rise[BTN_INC] & ~btn_rise[BTN_NEXT] & ~ev_clr;

   // EDIT_P2..EDIT_B0 map onto digit indices 4..0.
   assign in_edit = (state < CONFIRM);
   assign sel_idx = 3'(DIGIT_P2) - state;

   // BCD to binary by shift-add: x100 = x64+x32+x4, x10 = x8+x2.
   assign pills_bin = {digits[DIGIT_P2], 6'b0}
                    + {1'b0, digits[DIGIT_P2], 5'b0}
                    + {4'b0, digits[DIGIT_P2], 2'b0}
                    + {3'b0, digits[DIGIT_P1], 3'b0}
                    + {5'b0, digits[DIGIT_P1], 1'b0}
                    + {6'b0, digits[DIGIT_P0]};
   assign bottles_bin = {digits[DIGIT_B1], 3'b0}
                      + {2'b0, digits[DIGIT_B1], 1'b0}
                      + {3'b0, digits[DIGIT_B0]};

   // Both the pill and the bottle setting must be non-zero to start.
   assign setting_ok = (|digits[DIGIT_P2:DIGIT_P0]) & (|digits[DIGIT_B1:DIGIT_B0]);

   // Edit FSM, digit registers, committed targets and strobes.
   always_ff @(posedge clk_1khz or negedge rst_n) begin
      if (!rst_n) begin
         state          <= EDIT_P2;
         digits         <= '0;
         target_pills   <= '0;
         target_bottles <= '0;
         start_pulse    <= 1'b0;
         reject_pulse   <= 1'b0;
      end else begin
         start_pulse  <= 1'b0;
         reject_pulse <= 1'b0;
         if (ev_clr) begin
            // Unlocking keeps the committed digits so they can be re-confirmed.
            state <= EDIT_P2;
            if (state != LOCKED) digits <= '0;
         end else if (ev_next) begin
            case (state)
               CONFIRM: begin
                  if (setting_ok) begin
                     target_pills   <= pills_bin;
                     target_bottles <= bottles_bin;
                     state          <= LOCKED;
                     start_pulse    <= 1'b1;
                  end else begin
                     state        <= EDIT_P2;
                     reject_pulse <= 1'b1;
                  end
               end
               LOCKED:  ;
               default: state <= state + 3'd1;
            endcase
         end else if (ev_inc && in_edit) begin
            digits[sel_idx] <= (digits[sel_idx] == 4'd9) ? 4'd0 : digits[sel_idx] + 4'd1;
         end
      end
   end

   // Display blink mask follows the selected digit.
   always_comb begin
      flicker_mask = '0;
      if (in_edit)               flicker_mask[sel_idx] = 1'b1;
      else if (state == CONFIRM) flicker_mask = '1;
   end

   assign locked      = (state == LOCKED);
   assign disp_digits = digits;

endmodule
